mont_adder_sequencer: RTL and testbench
=======================================

// Module: mont_adder_sequencer
// PURPOSE
//  Control FSM that sequences the multi-precision carry-save adder datapath through one Montgomery multiplication.
//  Phases, in order:
//  - clear the datapath
//  - N_ITER carry-save iterations (c_doubleshift pulses)
//  - 6-phase chunked carry-propagate resolve
//  - repeated 6-phase conditional-subtract passes until the datapath reports subtract_finished
//  Sits between the top-level command FSM (start/done) and the adder datapath.
// PARAMETERS
//  N_ITER      128  carry-save iterations per multiplication (4 result bits retired per iteration)
//  MAX_SUB     3    maximum subtract passes before err is raised
//  PHASE_IDLE  4'hF value driven on phase when not resolving; bit 3 set freezes the datapath pipeline/carry regs
// PORTS
//  clk               in   1   system clock
//  resetn            in   1   asynchronous active-low reset
//  start             in   1   begin operation; sampled only in IDLE
//  subtract_finished in   1   datapath: subtract pass underflowed, previous result final (valid at phase 5)
//  dp_clear_n        out  1   active-low synchronous clear to datapath regs
//  c_doubleshift     out  1   datapath: advance carry-save accumulator one iteration
//  phase             out  4   datapath chunk phase (0..5, or PHASE_IDLE)
//  subtract          out  1   datapath: current resolve pass is a subtraction
//  iter_idx          out  7   current iteration index (digit select for operand muxing)
//  busy              out  1   high from accepted start until done
//  done              out  1   one-cycle pulse: result stable on datapath trueResult
//  err               out  1   sticky until next start: MAX_SUB passes without subtract_finished
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE; dp_clear_n=1, c_doubleshift=0, phase=PHASE_IDLE, subtract=0,
//    iter_idx=0, busy=0, done=0, err=0. Asserting resetn mid-operation aborts immediately; no done.
//  All outputs are registered (Moore); no combinational path from inputs to outputs.
//  States:
//  - IDLE:    start=1 -> CLEAR, busy<=1, err<=0. start while busy is ignored.
//  - CLEAR:   1 cycle, dp_clear_n=0 -> ITER.
//  - ITER:    c_doubleshift=1 for exactly N_ITER consecutive cycles. iter_idx counts 0..N_ITER-1, wraps to 0 on exit -> RESOLVE.
//  - RESOLVE: subtract=0, phase 0,1,2,3,4,5 on consecutive cycles (6 cycles) -> SUB, pass count <= 0.
//  - SUB:     subtract=1, phase 0..5 (6 cycles). On the phase-5 cycle, sample subtract_finished:
//    - 1 -> DONE.
//    - 0 and pass count = MAX_SUB-1 -> DONE with err<=1.
//    - 0 otherwise -> pass count++, restart at phase 0.
//  - DONE:    done=1 for one cycle, busy<=0, phase=PHASE_IDLE -> IDLE.
//  Latency: start to done = 1 + 1 + N_ITER + 6 + 6*P + 1 cycles, P = subtract passes (1..MAX_SUB).
//  Sub-state timing:
//  - phase changes every cycle inside RESOLVE/SUB; never skips or repeats a value.
//  - phase = PHASE_IDLE in IDLE/CLEAR/ITER/DONE.
//  - subtract and c_doubleshift are never both 1.
//  - c_doubleshift=0 outside ITER.
//  start and a DONE cycle coincident: the start is ignored (not IDLE); it must be re-asserted.
// CONFIGURATION
//  MONT_SEQ_PERF_EN defined:
//  - adds output cyc_cnt[15:0], cleared on an accepted start, increments every busy cycle, saturates at 16'hFFFF.
//  - adds output sub_passes[1:0], the pass count at done.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package mont_pkg:
//  - state encoding constants (IDLE, CLEAR, ITER, RESOLVE, SUB, DONE)
//  - PHASE_LAST=4'd5, PHASE_IDLE, N_ITER default
//  Reused by the top-level command FSM.
//  One sub-module: mont_phase_ctr.
//  - 0..5 phase counter with load/enable and a last-phase flag.
//  - used by RESOLVE and SUB.
//  Iteration counter and pass counter stay inline.
// TESTING
//  1. Reset mid-ITER (iter_idx=40): all outputs return to reset values immediately; a later start runs a full op.
//  2. start, subtract_finished=1 on first SUB phase 5: done 1+1+128+6+6+1=143 cycles after start; err=0; one c_doubleshift burst of exactly 128.
//  3. subtract_finished=1 only on second pass: 6 extra cycles (149); phase sequence 0..5 seen three times total.
//  4. subtract_finished never 1, MAX_SUB=3: done at 155 cycles with err=1; err clears on next accepted start.
//  5. start held high through DONE: no second CLEAR until a fresh start is sampled in IDLE; start while busy has no effect.
//  6. MONT_SEQ_PERF_EN: case 2 gives cyc_cnt=143, sub_passes=0; build without macro compiles with ports absent.

Source files
------------

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery sequencer and the top-level command FSM:
// state encoding, phase constants and the default iteration count.
package mont_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ITER    = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_SUB     = 3'd4,
        ST_DONE    = 3'd5
    } mont_state_t;

    localparam logic [3:0] PHASE_LAST = 4'd5;
    localparam logic [3:0] PHASE_IDLE = 4'hF;
    localparam int         N_ITER_DEF = 128;

endpackage

// File: rtl/mont_phase_ctr.sv
// Chunk phase counter 0..5 for the resolve and subtract passes; parks at PHASE_IDLE
// whenever neither load nor enable is asserted, which freezes the datapath.
module mont_phase_ctr
    import mont_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic       en,
    output logic [3:0] phase,
    output logic       last
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase <= PHASE_IDLE;
        end else if (load) begin
            phase <= 4'd0;
        end else if (en) begin
            phase <= phase + 4'd1;
        end else begin
            phase <= PHASE_IDLE;
        end
    end

    assign last = (phase == PHASE_LAST);

endmodule

// File: rtl/mont_adder_sequencer.sv
// Sequences the carry-save adder datapath through clear, N_ITER iterations, resolve and
// conditional-subtract passes. Optional MONT_SEQ_PERF_EN adds cyc_cnt and sub_passes.
module mont_adder_sequencer
    import mont_pkg::*;
#(
    parameter int N_ITER  = N_ITER_DEF,
    parameter int MAX_SUB = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        subtract_finished,
    output logic        dp_clear_n,
    output logic        c_doubleshift,
    output logic [3:0]  phase,
    output logic        subtract,
    output logic [6:0]  iter_idx,
    output logic        busy,
    output logic        done,
    output logic        err
`ifdef MONT_SEQ_PERF_EN
    ,
    output logic [15:0] cyc_cnt,
    output logic [1:0]  sub_passes
`endif
);

    localparam logic [6:0] ITER_LAST = 7'(N_ITER - 1);
    localparam logic [1:0] SUB_LAST  = 2'(MAX_SUB - 1);

    mont_state_t state, next_state;
    logic [1:0]  pass_cnt;
    logic        pass_clr, pass_inc, set_err;
    logic        ph_load, ph_en, ph_last;

    mont_phase_ctr u_phase_ctr (
        .clk    (clk),
        .resetn (resetn),
        .load   (ph_load),
        .en     (ph_en),
        .phase  (phase),
        .last   (ph_last)
    );

    always_comb begin
        next_state = state;
        ph_load    = 1'b0;
        ph_en      = 1'b0;
        pass_clr   = 1'b0;
        pass_inc   = 1'b0;
        set_err    = 1'b0;
        case (state)
            ST_IDLE:  if (start) next_state = ST_CLEAR;
            ST_CLEAR: next_state = ST_ITER;
            ST_ITER: begin
                if (iter_idx == ITER_LAST) begin
                    next_state = ST_RESOLVE;
                    ph_load    = 1'b1;
                end
            end
            ST_RESOLVE: begin
                if (ph_last) begin
                    next_state = ST_SUB;
                    ph_load    = 1'b1;
                    pass_clr   = 1'b1;
                end else begin
                    ph_en = 1'b1;
                end
            end
            ST_SUB: begin
                // Underflow on the last chunk means the previous pass already holds the result
                if (ph_last) begin
                    if (subtract_finished) begin
                        next_state = ST_DONE;
                    end else if (pass_cnt == SUB_LAST) begin
                        next_state = ST_DONE;
                        set_err    = 1'b1;
                    end else begin
                        pass_inc = 1'b1;
                        ph_load  = 1'b1;
                    end
                end else begin
                    ph_en = 1'b1;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from next_state and registered so they align with the state they describe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            dp_clear_n    <= 1'b1;
            c_doubleshift <= 1'b0;
            subtract      <= 1'b0;
            iter_idx      <= 7'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            pass_cnt      <= 2'd0;
        end else begin
            state         <= next_state;
            dp_clear_n    <= (next_state != ST_CLEAR);
            c_doubleshift <= (next_state == ST_ITER);
            subtract      <= (next_state == ST_SUB);
            done          <= (next_state == ST_DONE);
            busy          <= (next_state != ST_IDLE);
            iter_idx      <= (state == ST_ITER && next_state == ST_ITER) ? iter_idx + 7'd1 : 7'd0;
            if (state == ST_IDLE && start) begin
                err <= 1'b0;
            end else if (set_err) begin
                err <= 1'b1;
            end
            if (pass_clr) begin
                pass_cnt <= 2'd0;
            end else if (pass_inc) begin
                pass_cnt <= pass_cnt + 2'd1;
            end
        end
    end

`ifdef MONT_SEQ_PERF_EN
    // The accepting IDLE cycle counts as the first cycle of the operation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cyc_cnt    <= 16'd0;
            sub_passes <= 2'd0;
        end else begin
            if (state == ST_IDLE && start) begin
                cyc_cnt <= 16'd1;
            end else if (busy && cyc_cnt != 16'hFFFF) begin
                cyc_cnt <= cyc_cnt + 16'd1;
            end
            if (state == ST_SUB && next_state == ST_DONE) begin
                sub_passes <= pass_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mont_adder_sequencer.sv
// Self-checking bench for mont_adder_sequencer: vector table, hand-written corner sequences
// and randomized operations against an arithmetic latency/pass model.
module tb_mont_adder_sequencer;

    localparam int N_ITER  = 128;
    localparam int MAX_SUB = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       sf;
    logic       dp_clear_n;
    logic       c_doubleshift;
    logic [3:0] phase;
    logic       subtract;
    logic [6:0] iter_idx;
    logic       busy;
    logic       done;
    logic       err;
`ifdef MONT_SEQ_PERF_EN
    logic [15:0] cyc_cnt;
    logic [1:0]  sub_passes;
`endif

    int checks   = 0;
    int failures = 0;

    mont_adder_sequencer #(.N_ITER(N_ITER), .MAX_SUB(MAX_SUB)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .start             (start),
        .subtract_finished (sf),
        .dp_clear_n        (dp_clear_n),
        .c_doubleshift     (c_doubleshift),
        .phase             (phase),
        .subtract          (subtract),
        .iter_idx          (iter_idx),
        .busy              (busy),
        .done              (done),
        .err               (err)
`ifdef MONT_SEQ_PERF_EN
        ,
        .cyc_cnt           (cyc_cnt),
        .sub_passes        (sub_passes)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int target;   // pass on which subtract_finished is reported (0 = never)
        int exp_lat;
        int exp_err;
        int exp_seqs;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_passes(input int target);
        return (target >= 1 && target <= MAX_SUB) ? target : MAX_SUB;
    endfunction

    function automatic int model_lat(input int target);
        return 1 + 1 + N_ITER + 6 + 6 * model_passes(target) + 1;
    endfunction

    function automatic int model_err(input int target);
        return (target >= 1 && target <= MAX_SUB) ? 0 : 1;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dp_clear_n"}, int'(dp_clear_n), 1);
        chk({tag, "_c_doubleshift"}, int'(c_doubleshift), 0);
        chk({tag, "_phase"}, int'(phase), 15);
        chk({tag, "_subtract"}, int'(subtract), 0);
        chk({tag, "_iter_idx"}, int'(iter_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    // Runs one operation from start to the first IDLE cycle after done, observing on negedges
    task automatic run_op(input string tag, input int target, input bit hold,
                          output int lat, output int err_o, output int ds, output int seqs,
                          output int viol, output int clr_cyc, output int err_clr);
        int  cyc;
        int  prev;
        int  sub5;
        bit  seen;
        cyc = 1; prev = 15; sub5 = 0; seen = 0;
        lat = -1; err_o = -1; ds = 0; seqs = 0; viol = 0; clr_cyc = -1; err_clr = -1;
        @(negedge clk);
        start = 1'b1;
        sf    = 1'b0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (!dp_clear_n) begin
                if (clr_cyc < 0) clr_cyc = cyc;
                else viol++;
                err_clr = int'(err);
            end
            if (c_doubleshift) begin
                if (iter_idx != 7'(ds)) viol++;
                if (phase != 4'hF || subtract) viol++;
                ds++;
            end
            if (phase != 4'hF) begin
                if (int'(phase) != ((prev == 15 || prev == 5) ? 0 : prev + 1)) viol++;
                if (phase == 4'd5) seqs++;
            end else if (prev != 15 && prev != 5) begin
                viol++;
            end
            if (subtract && phase == 4'd5) begin
                sub5++;
                sf = (sub5 == target);
            end else begin
                sf = 1'b0;
            end
            prev = int'(phase);
            if (done) begin
                seen  = 1'b1;
                lat   = cyc;
                err_o = int'(err);
            end
        end
        sf = 1'b0;
        if (!seen) chk({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_done_after"}, int'(done), 0);
`ifdef MONT_SEQ_PERF_EN
        chk({tag, "_cyc_cnt"}, int'(cyc_cnt), model_lat(target));
        chk({tag, "_sub_passes"}, int'(sub_passes), model_passes(target) - 1);
`endif
    endtask

    task automatic check_op(input string tag, input int target, input bit hold,
                            input int exp_lat, input int exp_err, input int exp_seqs);
        int lat, e, ds, seqs, viol, clr_cyc, err_clr;
        run_op(tag, target, hold, lat, e, ds, seqs, viol, clr_cyc, err_clr);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_err"}, e, exp_err);
        chk({tag, "_doubleshift_cnt"}, ds, N_ITER);
        chk({tag, "_phase_seqs"}, seqs, exp_seqs);
        chk({tag, "_seq_violations"}, viol, 0);
        chk({tag, "_clear_cycle"}, clr_cyc, 2);
        chk({tag, "_err_cleared_on_start"}, err_clr, 0);
    endtask

    vec_t vecs[3];

    initial begin
        vecs[0] = '{target: 1, exp_lat: 143, exp_err: 0, exp_seqs: 2};
        vecs[1] = '{target: 2, exp_lat: 149, exp_err: 0, exp_seqs: 3};
        vecs[2] = '{target: 0, exp_lat: 155, exp_err: 1, exp_seqs: 4};

        resetn = 1'b0;
        start  = 1'b0;
        sf     = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].target, 1'b0,
                     vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_seqs);
        end

        // start held through busy and the DONE cycle: neither may start another op
        check_op("hold", 1, 1'b1, 143, 0, 2);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_idle%0d_busy", i), int'(busy), 0);
            chk($sformatf("hold_idle%0d_clear_n", i), int'(dp_clear_n), 1);
        end

        // Asynchronous reset in the middle of the iteration burst
        begin
            bit hit;
            hit = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                @(negedge clk);
                if (c_doubleshift && iter_idx == 7'd40) hit = 1'b1;
            end
            chk("midreset_reached_iter40", int'(hit), 1);
            resetn = 1'b0;
            #1;
            check_reset_vals("midreset");
            @(negedge clk);
            chk("midreset_no_done", int'(done), 0);
            resetn = 1'b1;
            @(negedge clk);
        end
        check_op("after_reset", 1, 1'b0, 143, 0, 2);

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            int t;
            int gap;
            t   = int'($urandom_range(0, 4));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            check_op($sformatf("rnd%0d_t%0d", i, t), t, 1'b0,
                     model_lat(t), model_err(t), model_passes(t) + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
